// File: rtl/memory_split_if.sv
// EX-side inputs and ME-side outputs of the data-memory stage.
// The master drives EX/pipeline controls, the slave returns ME results.
interface memory_split_if #(
    parameter int CNT_W = 16
);
    logic             flush;
    logic             AnyStall;
    logic [31:0]      Result_EX;
    logic [31:0]      WrDat_EX;
    logic             RegWrite_EX;
    logic             MemToReg_EX;
    logic             MemWrite_EX;
    logic [4:0]       WriteReg_EX;
    logic [1:0]       Size_EX;
    logic             Unsigned_EX;
    logic             InstrVal_EX;
    logic [31:0]      RdDat_ME;
    logic [31:0]      Result_ME;
    logic [31:0]      ResultRdDat_ME;
    logic             RegWrite_ME;
    logic             MemToReg_ME;
    logic [4:0]       WriteReg_ME;
    logic             MisAlignStall_MEM1;
    logic [CNT_W-1:0] Cycles_ME;
    logic [CNT_W-1:0] Instr_ME;

    modport master (
        output flush, AnyStall, Result_EX, WrDat_EX,
        output RegWrite_EX, MemToReg_EX, MemWrite_EX,
        output WriteReg_EX, Size_EX, Unsigned_EX, InstrVal_EX,
        input  RdDat_ME, Result_ME, ResultRdDat_ME,
        input  RegWrite_ME, MemToReg_ME, WriteReg_ME,
        input  MisAlignStall_MEM1, Cycles_ME, Instr_ME
    );

    modport slave (
        input  flush, AnyStall, Result_EX, WrDat_EX,
        input  RegWrite_EX, MemToReg_EX, MemWrite_EX,
        input  WriteReg_EX, Size_EX, Unsigned_EX, InstrVal_EX,
        output RdDat_ME, Result_ME, ResultRdDat_ME,
        output RegWrite_ME, MemToReg_ME, WriteReg_ME,
        output MisAlignStall_MEM1, Cycles_ME, Instr_ME
    );
endinterface

// File: rtl/memory_split.sv
// Data-memory stage: big-endian byte/half/word RAM access with
// word-crossing accesses split over two cycles, ME register and counters.
module memory_split #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    memory_split_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        SECOND
    } state_e;

    state_e           state_q;
    logic [31:0]      hold_q;
    logic [31:0]      rd_dat_q;
    logic [31:0]      result_q;
    logic             reg_write_q;
    logic             mem_to_reg_q;
    logic [4:0]       write_reg_q;
    logic [CNT_W-1:0] cycles_q;
    logic [CNT_W-1:0] instr_q;

    logic [31:0] mem_q [DEPTH];

    logic [AW-1:0] widx;
    logic [AW-1:0] widx1;
    logic [1:0]    off;
    logic          is_mem;
    logic          is_word;
    logic          is_half;
    logic          split;
    logic          first;

    assign widx    = bus.Result_EX[AW+1:2];
    assign widx1   = widx + AW'(1);
    assign off     = bus.Result_EX[1:0];
    assign is_mem  = bus.MemWrite_EX | bus.MemToReg_EX;
    assign is_word = bus.Size_EX[1];
    assign is_half = (bus.Size_EX == 2'b01);
    assign split   = is_mem & ((is_half & (off == 2'd3)) |
                               (is_word & (off != 2'd0)));
    assign first   = (state_q == IDLE) & split;

    assign bus.MisAlignStall_MEM1 = first;

    // Two-word window: the accessed bytes always start at byte 'off'.
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [63:0] ld_win;
    logic [63:0] ld_sh;
    logic [31:0] ld_top;
    logic [31:0] ld_d;

    assign rd0    = mem_q[widx];
    assign rd1    = mem_q[widx1];
    assign ld_win = (state_q == SECOND) ? {hold_q, rd1} : {rd0, 32'h0};
    assign ld_sh  = ld_win << {off, 3'b000};
    assign ld_top = ld_sh[63:32];

    always_comb begin
        ld_d = ld_top;
        unique case (1'b1)
            is_word: ld_d = ld_top;
            is_half: ld_d = {{16{~bus.Unsigned_EX & ld_top[31]}},
                             ld_top[31:16]};
            default: ld_d = {{24{~bus.Unsigned_EX & ld_top[31]}},
                             ld_top[31:24]};
        endcase
    end

    logic [31:0] st_al;
    logic [3:0]  st_m;
    logic [63:0] st_win;
    logic [7:0]  st_be;
    logic        wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0] wr_dat;
    logic [3:0]  wr_be;

    always_comb begin
        st_al = bus.WrDat_EX;
        st_m  = 4'b1111;
        unique case (1'b1)
            is_word: begin
                st_al = bus.WrDat_EX;
                st_m  = 4'b1111;
            end
            is_half: begin
                st_al = {bus.WrDat_EX[15:0], 16'h0};
                st_m  = 4'b1100;
            end
            default: begin
                st_al = {bus.WrDat_EX[7:0], 24'h0};
                st_m  = 4'b1000;
            end
        endcase
    end

    assign st_win = {st_al, 32'h0} >> {off, 3'b000};
    assign st_be  = {st_m, 4'h0} >> off;
    assign wr_en  = bus.MemWrite_EX & ~bus.AnyStall & ~bus.flush;
    assign wr_idx = (state_q == SECOND) ? widx1 : widx;
    assign wr_dat = (state_q == SECOND) ? st_win[31:0] : st_win[63:32];
    assign wr_be  = (state_q == SECOND) ? st_be[3:0] : st_be[7:4];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            rd_dat_q     <= '0;
            result_q     <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            write_reg_q  <= '0;
            cycles_q     <= '0;
            instr_q      <= '0;
        end else if (bus.flush) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            rd_dat_q     <= '0;
            result_q     <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            write_reg_q  <= '0;
            cycles_q     <= '0;
            instr_q      <= '0;
        end else begin
            cycles_q <= cycles_q + CNT_W'(1);
            if (!bus.AnyStall) begin
                if (bus.InstrVal_EX && !first) begin
                    instr_q <= instr_q + CNT_W'(1);
                end
                if (first) begin
                    // First half: park word N and send a bubble to ME.
                    state_q      <= SECOND;
                    hold_q       <= rd0;
                    rd_dat_q     <= '0;
                    result_q     <= '0;
                    reg_write_q  <= 1'b0;
                    mem_to_reg_q <= 1'b0;
                    write_reg_q  <= '0;
                end else begin
                    state_q      <= IDLE;
                    hold_q       <= '0;
                    rd_dat_q     <= ld_d;
                    result_q     <= bus.Result_EX;
                    reg_write_q  <= bus.RegWrite_EX;
                    mem_to_reg_q <= bus.MemToReg_EX;
                    write_reg_q  <= bus.WriteReg_EX;
                end
            end
        end
    end

    assign bus.RdDat_ME       = rd_dat_q;
    assign bus.Result_ME      = result_q;
    assign bus.RegWrite_ME    = reg_write_q;
    assign bus.MemToReg_ME    = mem_to_reg_q;
    assign bus.WriteReg_ME    = write_reg_q;
    assign bus.ResultRdDat_ME = mem_to_reg_q ? rd_dat_q : result_q;
    assign bus.Cycles_ME      = cycles_q;
    assign bus.Instr_ME       = instr_q;
endmodule

// File: tb/tb_memory_split.sv
// Directed bench for memory_split with a 4-word RAM and 4-bit counters.
// Vector table for single accesses, hand sequences for stall/flush/reset.
module tb_memory_split;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    memory_split_if #(.CNT_W(CW)) bus ();

    memory_split #(
        .DEPTH (4),
        .CNT_W (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       nm;
        logic        st;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic        uns;
        logic        split;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mkv(string nm, logic st, logic [31:0] addr,
                                 logic [31:0] wd, logic [1:0] sz,
                                 logic uns, logic split,
                                 logic [31:0] exp);
        vec_t v;
        v.nm = nm; v.st = st; v.addr = addr; v.wd = wd;
        v.sz = sz; v.uns = uns; v.split = split; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.MemWrite_EX = 1'b0;
        bus.MemToReg_EX = 1'b0;
        bus.RegWrite_EX = 1'b0;
        bus.WriteReg_EX = 5'd0;
        bus.InstrVal_EX = 1'b0;
        bus.Result_EX   = 32'h0;
        bus.WrDat_EX    = 32'h0;
        bus.Size_EX     = 2'd0;
        bus.Unsigned_EX = 1'b0;
    endtask

    task automatic drive(input logic st, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz,
                         input logic uns);
        bus.MemWrite_EX = st;
        bus.MemToReg_EX = ~st;
        bus.RegWrite_EX = ~st;
        bus.WriteReg_EX = st ? 5'd0 : 5'd9;
        bus.InstrVal_EX = 1'b1;
        bus.Result_EX   = a;
        bus.WrDat_EX    = wd;
        bus.Size_EX     = sz;
        bus.Unsigned_EX = uns;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v.st, v.addr, v.wd, v.sz, v.uns);
        #1 chk({v.nm, " stall"}, 32'(bus.MisAlignStall_MEM1), 32'(v.split));
        if (v.split) begin
            @(posedge clk);
            #1 chk({v.nm, " bubble"}, 32'(bus.RegWrite_ME), 32'd0);
            @(negedge clk);
            chk({v.nm, " stall2"}, 32'(bus.MisAlignStall_MEM1), 32'd0);
        end
        @(posedge clk);
        #1;
        if (!v.st) begin
            chk({v.nm, " rd"}, bus.RdDat_ME, v.exp);
            chk({v.nm, " wb"}, bus.ResultRdDat_ME, v.exp);
            chk({v.nm, " ctl"},
                {26'd0, bus.RegWrite_ME, bus.WriteReg_ME}, 32'h29);
        end
        idle();
    endtask

    initial begin
        bus.flush    = 1'b0;
        bus.AnyStall = 1'b0;
        idle();

        // stores/loads: st, addr, wdata, size, unsigned, split, expected
        vt.push_back(mkv("sw w0", 1, 0, 32'h11223344, 2, 0, 0, 0));
        vt.push_back(mkv("sw w1", 1, 4, 32'h55667788, 2, 0, 0, 0));
        vt.push_back(mkv("lw 0", 0, 0, 0, 2, 0, 0, 32'h11223344));
        vt.push_back(mkv("lw 2", 0, 2, 0, 2, 0, 1, 32'h33445566));
        vt.push_back(mkv("sw 80ff", 1, 0, 32'h80FF0011, 2, 0, 0, 0));
        vt.push_back(mkv("lb 0", 0, 0, 0, 0, 0, 0, 32'hFFFFFF80));
        vt.push_back(mkv("lbu 0", 0, 0, 0, 0, 1, 0, 32'h00000080));
        vt.push_back(mkv("lh 2", 0, 2, 0, 1, 0, 0, 32'h00000011));
        vt.push_back(mkv("lh 0", 0, 0, 0, 1, 0, 0, 32'hFFFF80FF));
        vt.push_back(mkv("lhu 1", 0, 1, 0, 1, 1, 0, 32'h0000FF00));
        vt.push_back(mkv("clr w0", 1, 0, 0, 2, 0, 0, 0));
        vt.push_back(mkv("clr w1", 1, 4, 0, 2, 0, 0, 0));
        vt.push_back(mkv("sh 3", 1, 3, 32'h0000AABB, 1, 0, 1, 0));
        vt.push_back(mkv("lw w0 aa", 0, 0, 0, 2, 0, 0, 32'h000000AA));
        vt.push_back(mkv("lw w1 bb", 0, 4, 0, 2, 0, 0, 32'hBB000000));
        vt.push_back(mkv("sw w3", 1, 12, 32'hCAFEBABE, 2, 0, 0, 0));
        vt.push_back(mkv("sw w0b", 1, 0, 32'h12345678, 2, 0, 0, 0));
        vt.push_back(mkv("lw 13", 0, 13, 0, 2, 0, 1, 32'hFEBABE12));
        vt.push_back(mkv("sb 5", 1, 5, 32'hFFFFFF5A, 0, 0, 0, 0));
        vt.push_back(mkv("lw w1 5a", 0, 4, 0, 2, 0, 0, 32'hBB5A0000));
        vt.push_back(mkv("lh 3", 0, 3, 0, 1, 0, 1, 32'h000078BB));
        vt.push_back(mkv("lb 4", 0, 4, 0, 0, 0, 0, 32'hFFFFFFBB));
        vt.push_back(mkv("lw 1", 0, 1, 0, 2, 0, 1, 32'h345678BB));
        vt.push_back(mkv("lw sz3", 0, 0, 0, 3, 1, 0, 32'h12345678));
        vt.push_back(mkv("sh 15", 1, 15, 32'hFFFF1357, 1, 0, 1, 0));
        vt.push_back(mkv("lw hi", 0, 32'h100C, 0, 2, 0, 0, 32'hCAFEBA13));
        vt.push_back(mkv("lw w0c", 0, 0, 0, 2, 0, 0, 32'h57345678));
        vt.push_back(mkv("clr w2", 1, 8, 0, 2, 0, 0, 0));

        #1 reset = 1'b1;
        #1;
        chk("rst rd", bus.RdDat_ME, 32'h0);
        chk("rst ctl", {bus.RegWrite_ME, bus.MemToReg_ME,
                        bus.WriteReg_ME, bus.Result_ME}, 39'h0);
        chk("rst cnt", {bus.Cycles_ME, bus.Instr_ME}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vt[i]) apply(vt[i]);

        // split store held by AnyStall in the second half
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 chk("flush cnt", {bus.Cycles_ME, bus.Instr_ME}, 32'h0);
        @(negedge clk);
        bus.flush = 1'b0;
        drive(1, 6, 32'hDEADBEEF, 2, 0);
        #1 chk("ss stall", 32'(bus.MisAlignStall_MEM1), 32'd1);
        @(posedge clk);
        #1 chk("ss cnt1", {bus.Cycles_ME, bus.Instr_ME}, 32'h10);
        @(negedge clk);
        bus.AnyStall = 1'b1;
        #1 chk("ss stall2", 32'(bus.MisAlignStall_MEM1), 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("ss cnt4", {bus.Cycles_ME, bus.Instr_ME}, 32'h40);
        @(negedge clk);
        bus.AnyStall = 1'b0;
        #1 chk("ss held", 32'(bus.MisAlignStall_MEM1), 32'd0);
        @(posedge clk);
        #1 chk("ss cnt5", {bus.Cycles_ME, bus.Instr_ME}, 32'h51);
        idle();
        apply(mkv("ss w1", 0, 4, 0, 2, 0, 0, 32'hBB5ADEAD));
        apply(mkv("ss w2", 0, 8, 0, 2, 0, 0, 32'hBEEF0000));

        // AnyStall blocks an aligned store
        @(negedge clk);
        bus.AnyStall = 1'b1;
        drive(1, 8, 32'hFFFFFFFF, 2, 0);
        @(posedge clk);
        #1 bus.AnyStall = 1'b0;
        idle();
        apply(mkv("stall nowr", 0, 8, 0, 2, 0, 0, 32'hBEEF0000));

        // flush beats AnyStall, clears ME and blocks the store
        apply(mkv("pre flush", 0, 4, 0, 2, 0, 0, 32'hBB5ADEAD));
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.AnyStall = 1'b1;
        drive(1, 4, 32'h0, 2, 0);
        @(posedge clk);
        #1;
        chk("fl rd", bus.RdDat_ME, 32'h0);
        chk("fl ctl", {bus.RegWrite_ME, bus.MemToReg_ME,
                       bus.WriteReg_ME, bus.Result_ME}, 39'h0);
        chk("fl cnt", {bus.Cycles_ME, bus.Instr_ME}, 32'h0);
        bus.flush    = 1'b0;
        bus.AnyStall = 1'b0;
        idle();
        apply(mkv("fl nowr", 0, 4, 0, 2, 0, 0, 32'hBB5ADEAD));

        // flush in the second half restarts the split
        @(negedge clk);
        drive(0, 2, 0, 2, 0);
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        #1 chk("fl idle", 32'(bus.MisAlignStall_MEM1), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("fl s2", 32'(bus.MisAlignStall_MEM1), 32'd0);
        @(posedge clk);
        #1 chk("fl split", bus.RdDat_ME, 32'h5678BB5A);
        idle();

        // reset in the second half, then counters from zero
        @(negedge clk);
        drive(0, 2, 0, 2, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mr cnt", {bus.Cycles_ME, bus.Instr_ME}, 32'h0);
        chk("mr out", {bus.RegWrite_ME, bus.WriteReg_ME,
                       bus.RdDat_ME}, 38'h0);
        chk("mr idle", 32'(bus.MisAlignStall_MEM1), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 2, 0);
        @(posedge clk);
        #1;
        chk("mr lw", bus.RdDat_ME, 32'h57345678);
        chk("mr rw", 32'(bus.RegWrite_ME), 32'd1);
        chk("mr cnt1", {bus.Cycles_ME, bus.Instr_ME}, 32'h11);
        @(negedge clk);
        idle();
        bus.RegWrite_EX = 1'b1;
        bus.InstrVal_EX = 1'b1;
        bus.Result_EX   = 32'h000ABCDE;
        repeat (14) @(posedge clk);
        #1;
        chk("cnt 15", {bus.Cycles_ME, bus.Instr_ME}, 32'hFF);
        chk("alu wb", bus.ResultRdDat_ME, 32'h000ABCDE);
        @(posedge clk);
        #1 chk("cnt wrap", {bus.Cycles_ME, bus.Instr_ME}, 32'h00);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_split.md
Name: memory_split

Overview:
- Parametrised successor to the pipelined MEM1/ME data-memory stage.
- Contains an internal word RAM with byte-enable writes. Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Handles every access that crosses a word boundary, load or store, as a two-access split under a small FSM.
- Registers results into the ME write-back stage and carries parametrised performance counters.

Parameters:
- DEPTH, 64, number of 32-bit words in the data RAM; power of two, minimum 2.
- CNT_W, 16, width of the cycle and instruction performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- AnyStall  in  1  global pipeline stall.
- Result_EX  in  32  byte address, or ALU result for non-memory ops.
- WrDat_EX  in  32  store data, right-justified.
- RegWrite_EX, MemToReg_EX, MemWrite_EX  in  1 each  EX control bits.
- WriteReg_EX  in  5  destination register.
- Size_EX  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- Unsigned_EX  in  1  zero-extend loads when 1.
- InstrVal_EX  in  1  valid instruction in EX.
- RdDat_ME, Result_ME  out  32  registered load data and ALU result.
- ResultRdDat_ME  out  32  write-back mux: RdDat_ME if MemToReg_ME, else Result_ME.
- RegWrite_ME, MemToReg_ME  out  1 each  registered controls.
- WriteReg_ME  out  5  registered destination register.
- MisAlignStall_MEM1  out  1  request upstream to hold EX for one cycle.
- Cycles_ME, Instr_ME  out  CNT_W each  performance counters.

Behaviour:
- Byte order is big-endian: address offset 0 maps to bits [31:24].
- Word index is Result_EX[AW+1:2], where AW = log2(DEPTH). Upper address bits are ignored.
- RAM read is combinational. RAM write happens on the clock edge with a per-byte enable.
- Crossing rule: an access is "split" when it is half with offset 3, or word with offset not equal to 0. Byte accesses never split.
- FSM has two states, IDLE and SECOND.
  - IDLE, split memory access, no AnyStall:
    - access word N;
    - for stores, write only the bytes falling in word N;
    - for loads, capture word N into an internal hold register;
    - assert MisAlignStall_MEM1 combinationally in this cycle;
    - ME controls load a bubble (RegWrite_ME = 0);
    - next state SECOND.
  - SECOND:
    - access word (N+1) mod DEPTH, so the last word wraps to word 0;
    - stores write the remaining bytes;
    - loads merge the hold register with the current read, extend, and register into ME;
    - MisAlignStall_MEM1 = 0;
    - next state IDLE.
  - Upstream guarantees EX inputs are unchanged between the IDLE and SECOND cycles.
- Non-split accesses complete in one cycle. Load data is valid in ME the cycle after EX.
- Load extension:
  - byte and half loads are sign-extended from their MSB unless Unsigned_EX = 1;
  - word loads are unaffected by Unsigned_EX.
- Store lanes: the low 8/16/32 bits of WrDat_EX are placed on the addressed lanes. Other bytes of the word are unchanged.
- AnyStall:
  - blocks RAM writes;
  - ME registers and FSM state hold;
  - MisAlignStall_MEM1 is still computed from the inputs.
- flush:
  - next edge clears RdDat_ME, Result_ME, RegWrite_ME, MemToReg_ME and WriteReg_ME;
  - FSM returns to IDLE and the hold register clears;
  - blocks any RAM write in that cycle;
  - flush takes priority over AnyStall.
- reset: asynchronously clears every register (all ME outputs, FSM to IDLE, hold register, counters) to 0. RAM contents are not reset.
- Counters:
  - Cycles_ME increments every cycle that is not flushed;
  - Instr_ME increments when InstrVal_EX = 1, AnyStall = 0, and FSM is not issuing the first half of a split;
  - both wrap modulo 2^CNT_W;
  - flush clears both.

Test Plan:
- Preload word0 = 0x11223344, word1 = 0x55667788. Word load at addr 2 -> MisAlignStall_MEM1 = 1 for one cycle, then RdDat_ME = 0x33445566 with RegWrite_ME = 1.
- Word0 = 0x80FF0011. Byte load at addr 0: signed -> 0xFFFFFF80; Unsigned_EX = 1 -> 0x00000080. Half load at addr 2 -> 0x00000011.
- Half store 0xAABB at addr 3 over word0 = 0, word1 = 0 -> word0 = 0x000000AA, word1 = 0xBB000000. Stall asserted exactly one cycle.
- DEPTH = 4, word load at addr 13 -> second access reads word 0 (wrap). Result uses word3[23:0] followed by word0[31:24].
- Split store with AnyStall held 3 cycles in the SECOND state -> no extra writes; second half written once after the stall releases.
- Assert reset mid-split (state SECOND) -> outputs 0 immediately. Next aligned load completes normally. Counters restart from 0 and CNT_W = 4 wraps 15 -> 0.
